// File: rtl/micro_p_nios2_cpu_ocimem_arbiter.sv
// Arbiter sharing the single-port OCI RAM between the Avalon-MM slave port
// and the JTAG debug-slave path (one pending JTAG request, fair tie-break).
module micro_p_nios2_cpu_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [ADDR_W-1:0] av_address,
   input  logic [DATA_W-1:0] av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic              av_waitrequest,
   output logic [DATA_W-1:0] av_readdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wrdata,
   output logic [3:0]        ram_byteen,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_rddata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              jtag_rd_valid,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_AV_RD        = 3'd1;
   localparam logic [2:0] S_AV_RD_DONE   = 3'd2;
   localparam logic [2:0] S_JTAG_RD      = 3'd3;
   localparam logic [2:0] S_JTAG_RD_DONE = 3'd4;

   localparam logic GRANT_AV   = 1'b0;
   localparam logic GRANT_JTAG = 1'b1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
   logic              jtag_pend_q, jtag_pend_d;
   logic              jtag_is_rd_q, jtag_is_rd_d;
   logic [DATA_W-1:0] jtag_wdata_q, jtag_wdata_d;
   logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
   logic              last_grant_q, last_grant_d;
   logic              overrun_q, overrun_d;
   logic              av_req, strobe, jtag_done, accept;
   logic              unused_jdo;

   assign unused_jdo   = ^{jdo[37:36], jdo[1:0]};
   assign av_req       = av_read | av_write;
   assign strobe       = take_action_ocimem_a | take_action_ocimem_b;
   assign jtag_busy    = jtag_pend_q;
   assign jtag_overrun = overrun_q;

   // NOTE: every output and _d signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      jtag_addr_d    = jtag_addr_q;
      jtag_pend_d    = jtag_pend_q;
      jtag_is_rd_d   = jtag_is_rd_q;
      jtag_wdata_d   = jtag_wdata_q;
      mon_dreg_d     = mon_dreg_q;
      last_grant_d   = last_grant_q;
      overrun_d      = overrun_q;
      jtag_done      = 1'b0;
      av_waitrequest = 1'b1;
      av_readdata    = '0;
      ram_addr       = '0;
      ram_wrdata     = '0;
      ram_byteen     = '0;
      ram_wren       = 1'b0;
      ram_rden       = 1'b0;
      jtag_rd_valid  = 1'b0;
      MonDReg        = mon_dreg_q;

      case (state_q)
         S_IDLE: begin
            if (jtag_pend_q && (!av_req || last_grant_q == GRANT_AV)) begin
               last_grant_d = GRANT_JTAG;
               ram_addr     = jtag_addr_q;
               if (jtag_is_rd_q) begin
                  ram_rden = 1'b1;
                  state_d  = S_JTAG_RD;
               end else begin
                  ram_wren   = 1'b1;
                  ram_wrdata = jtag_wdata_q;
                  ram_byteen = 4'hF;
                  jtag_done  = 1'b1;
               end
            end else if (av_req) begin
               last_grant_d = GRANT_AV;
               ram_addr     = av_address;
               if (av_write) begin
                  ram_wren       = 1'b1;
                  ram_wrdata     = av_writedata;
                  ram_byteen     = av_byteenable;
                  av_waitrequest = 1'b0;
               end else begin
                  ram_rden = 1'b1;
                  state_d  = S_AV_RD;
               end
            end
         end
         // RAM data arrives here, one cycle after the grant; DONE is a turnaround cycle.
         S_AV_RD: begin
            av_waitrequest = 1'b0;
            av_readdata    = ram_rddata;
            state_d        = S_AV_RD_DONE;
         end
         S_JTAG_RD: begin
            jtag_rd_valid = 1'b1;
            MonDReg       = ram_rddata;
            mon_dreg_d    = ram_rddata;
            jtag_done     = 1'b1;
            state_d       = S_JTAG_RD_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (jtag_done) begin
         jtag_pend_d = 1'b0;
         jtag_addr_d = jtag_addr_q + ADDR_W'(1);
      end

      // A strobe landing on the completion cycle takes the freed slot.
      accept = strobe && (!jtag_pend_q || jtag_done);
      if (strobe && !accept) begin
         overrun_d = 1'b1;
      end else if (accept) begin
         if (take_action_ocimem_a) begin
            jtag_addr_d = jdo[ADDR_W+1:2];
            if (jdo[35]) begin
               jtag_pend_d  = 1'b1;
               jtag_is_rd_d = 1'b1;
            end
         end else begin
            jtag_pend_d  = 1'b1;
            jtag_is_rd_d = 1'b0;
            jtag_wdata_d = jdo[34:3];
         end
      end

      // NOTE: IDLE grants are combinational from av_* inputs, so reset must also mask the outputs directly.
      if (!reset_n) begin
         av_waitrequest = 1'b1;
         av_readdata    = '0;
         ram_addr       = '0;
         ram_wrdata     = '0;
         ram_byteen     = '0;
         ram_wren       = 1'b0;
         ram_rden       = 1'b0;
         jtag_rd_valid  = 1'b0;
         MonDReg        = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         jtag_addr_q  <= '0;
         jtag_pend_q  <= 1'b0;
         jtag_is_rd_q <= 1'b0;
         jtag_wdata_q <= '0;
         mon_dreg_q   <= '0;
         last_grant_q <= GRANT_AV;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         jtag_addr_q  <= jtag_addr_d;
         jtag_pend_q  <= jtag_pend_d;
         jtag_is_rd_q <= jtag_is_rd_d;
         jtag_wdata_q <= jtag_wdata_d;
         mon_dreg_q   <= mon_dreg_d;
         last_grant_q <= last_grant_d;
         overrun_q    <= overrun_d;
      end
   end

endmodule

// File: tb/tb_micro_p_nios2_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter; a small byte-lane RAM model with
// one-cycle read latency stands in for the OCI RAM.
module tb_micro_p_nios2_cpu_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b;
   logic        av_read, av_write;
   logic [7:0]  av_address;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wrdata;
   logic [3:0]  ram_byteen;
   logic        ram_wren, ram_rden;
   logic [31:0] ram_rddata = '0;
   logic [31:0] MonDReg;
   logic        jtag_rd_valid, jtag_busy, jtag_overrun;

   int n_checks = 0;
   int n_errors = 0;
   int wcnt;

   logic [31:0] mem [256];
   logic        preloaded = 1'b0;

   always #5 clk = ~clk;

   micro_p_nios2_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .jdo                  (jdo),
      .take_action_ocimem_a (take_action_ocimem_a),
      .take_action_ocimem_b (take_action_ocimem_b),
      .av_read              (av_read),
      .av_write             (av_write),
      .av_address           (av_address),
      .av_writedata         (av_writedata),
      .av_byteenable        (av_byteenable),
      .av_waitrequest       (av_waitrequest),
      .av_readdata          (av_readdata),
      .ram_addr             (ram_addr),
      .ram_wrdata           (ram_wrdata),
      .ram_byteen           (ram_byteen),
      .ram_wren             (ram_wren),
      .ram_rden             (ram_rden),
      .ram_rddata           (ram_rddata),
      .MonDReg              (MonDReg),
      .jtag_rd_valid        (jtag_rd_valid),
      .jtag_busy            (jtag_busy),
      .jtag_overrun         (jtag_overrun)
   );

   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[16]   <= 32'hDEADBEEF;
         mem[5]    <= 32'hAAAAAAAA;
         preloaded <= 1'b1;
      end else begin
         if (ram_wren)
            for (int b = 0; b < 4; b++)
               if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
         if (ram_rden) ram_rddata <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (ram_wren && ram_rden) check("wren_rden_exclusive", 32'(ram_rden), 32'd0);

   function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
      logic [37:0] j;
      j      = '0;
      j[35]  = rd;
      j[9:2] = a;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] j;
      j       = '0;
      j[34:3] = d;
      return j;
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      av_read = 1'b0;
      av_write = 1'b1;
      av_address = 8'h05;
      av_writedata = 32'h01020304;
      av_byteenable = 4'hF;

      // Reset values, with an Avalon write held to show outputs stay masked.
      repeat (2) @(posedge clk);
      at_neg();
      check("rst_waitreq", 32'(av_waitrequest), 32'd1);
      check("rst_readdata", av_readdata, 32'h0);
      check("rst_wren", 32'(ram_wren), 32'd0);
      check("rst_rden", 32'(ram_rden), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'h0);
      check("rst_wrdata", ram_wrdata, 32'h0);
      check("rst_byteen", 32'(ram_byteen), 32'h0);
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_rd_valid", 32'(jtag_rd_valid), 32'd0);
      check("rst_busy", 32'(jtag_busy), 32'd0);
      check("rst_overrun", 32'(jtag_overrun), 32'd0);
      next_cyc();
      av_write = 1'b0;
      reset_n  = 1'b1;

      // JTAG read of 0x10, then a write strobe on the read's completion cycle.
      next_cyc();
      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b1, 8'h10);
      at_neg();
      check("jrd_busy_strobe", 32'(jtag_busy), 32'd0);
      next_cyc();
      take_action_ocimem_a = 1'b0;
      at_neg();
      check("jrd_rden", 32'(ram_rden), 32'd1);
      check("jrd_addr", 32'(ram_addr), 32'h10);
      check("jrd_wren", 32'(ram_wren), 32'd0);
      check("jrd_busy", 32'(jtag_busy), 32'd1);
      next_cyc();
      take_action_ocimem_b = 1'b1;
      jdo = jdo_b(32'hCAFEF00D);
      at_neg();
      check("jrd_valid", 32'(jtag_rd_valid), 32'd1);
      check("jrd_mondreg", MonDReg, 32'hDEADBEEF);
      check("jrd_rden_off", 32'(ram_rden), 32'd0);
      next_cyc();
      take_action_ocimem_b = 1'b0;
      at_neg();
      check("jrd_valid_pulse", 32'(jtag_rd_valid), 32'd0);
      check("jrd_mondreg_hold", MonDReg, 32'hDEADBEEF);
      check("jrd_turnaround_wren", 32'(ram_wren), 32'd0);
      check("jwr_accepted_no_ovr", 32'(jtag_overrun), 32'd0);
      check("jwr_pending", 32'(jtag_busy), 32'd1);
      next_cyc();
      at_neg();
      check("jwr_wren", 32'(ram_wren), 32'd1);
      check("jwr_addr_incr", 32'(ram_addr), 32'h11);
      check("jwr_byteen", 32'(ram_byteen), 32'hF);
      check("jwr_data", ram_wrdata, 32'hCAFEF00D);
      next_cyc();
      at_neg();
      check("jwr_busy_drop", 32'(jtag_busy), 32'd0);
      check("jwr_wren_off", 32'(ram_wren), 32'd0);

      // Avalon partial write then read-back.
      next_cyc();
      av_write = 1'b1;
      av_address = 8'h05;
      av_writedata = 32'h12345678;
      av_byteenable = 4'b0011;
      at_neg();
      check("avwr_wren", 32'(ram_wren), 32'd1);
      check("avwr_addr", 32'(ram_addr), 32'h05);
      check("avwr_byteen", 32'(ram_byteen), 32'h3);
      check("avwr_data", ram_wrdata, 32'h12345678);
      check("avwr_waitreq", 32'(av_waitrequest), 32'd0);
      next_cyc();
      av_write = 1'b0;
      av_read  = 1'b1;
      at_neg();
      check("avrd1_wren", 32'(ram_wren), 32'd0);
      check("avrd1_rden", 32'(ram_rden), 32'd1);
      check("avrd1_waitreq", 32'(av_waitrequest), 32'd1);
      next_cyc();
      at_neg();
      check("avrd2_waitreq", 32'(av_waitrequest), 32'd0);
      check("avrd2_lanes", 32'(av_readdata[15:0]), 32'h5678);
      check("avrd2_data", av_readdata, 32'hAAAA5678);
      next_cyc();
      av_read = 1'b0;
      at_neg();
      check("avrd3_waitreq", 32'(av_waitrequest), 32'd1);
      check("avrd3_readdata", av_readdata, 32'h0);

      // Ties after reset: JTAG first, then a repeated tie goes to Avalon.
      next_cyc();
      reset_n = 1'b0;
      next_cyc();
      reset_n = 1'b1;
      next_cyc();
      take_action_ocimem_b = 1'b1;
      jdo = jdo_b(32'h11112222);
      next_cyc();
      jdo = jdo_b(32'h33334444);
      av_read = 1'b1;
      av_address = 8'h10;
      at_neg();
      check("tie1_jtag_wren", 32'(ram_wren), 32'd1);
      check("tie1_addr", 32'(ram_addr), 32'h00);
      check("tie1_data", ram_wrdata, 32'h11112222);
      check("tie1_av_wait", 32'(av_waitrequest), 32'd1);
      next_cyc();
      take_action_ocimem_b = 1'b0;
      at_neg();
      check("tie2_av_rden", 32'(ram_rden), 32'd1);
      check("tie2_av_addr", 32'(ram_addr), 32'h10);
      check("tie2_jtag_wait", 32'(ram_wren), 32'd0);
      check("tie2_no_ovr", 32'(jtag_overrun), 32'd0);
      next_cyc();
      at_neg();
      check("tie3_waitreq", 32'(av_waitrequest), 32'd0);
      check("tie3_data", av_readdata, 32'hDEADBEEF);
      next_cyc();
      av_read = 1'b0;
      at_neg();
      check("tie4_wren", 32'(ram_wren), 32'd0);
      check("tie4_busy", 32'(jtag_busy), 32'd1);
      next_cyc();
      at_neg();
      check("tie5_wren", 32'(ram_wren), 32'd1);
      check("tie5_addr", 32'(ram_addr), 32'h01);
      check("tie5_data", ram_wrdata, 32'h33334444);

      // Second strobe while the first is still pending is dropped.
      next_cyc();
      av_read = 1'b1;
      av_address = 8'h05;
      at_neg();
      check("ovr_av_rden", 32'(ram_rden), 32'd1);
      next_cyc();
      take_action_ocimem_b = 1'b1;
      jdo = jdo_b(32'h55556666);
      at_neg();
      check("ovr_av_data", av_readdata, 32'hAAAA5678);
      check("ovr_first_ok", 32'(jtag_overrun), 32'd0);
      next_cyc();
      av_read = 1'b0;
      jdo = jdo_b(32'h77778888);
      at_neg();
      check("ovr_busy", 32'(jtag_busy), 32'd1);
      wcnt = int'(ram_wren);
      next_cyc();
      take_action_ocimem_b = 1'b0;
      at_neg();
      check("ovr_sticky_set", 32'(jtag_overrun), 32'd1);
      check("ovr_wr_addr", 32'(ram_addr), 32'h02);
      check("ovr_wr_data", ram_wrdata, 32'h55556666);
      wcnt += int'(ram_wren);
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         at_neg();
         wcnt += int'(ram_wren);
      end
      check("ovr_one_wren", 32'(wcnt), 32'd1);
      check("ovr_mem", mem[2], 32'h55556666);
      check("ovr_still_set", 32'(jtag_overrun), 32'd1);

      // Address-only load to 0xFF, then writes wrap the address to 0x00.
      next_cyc();
      take_action_ocimem_a = 1'b1;
      jdo = jdo_a(1'b0, 8'hFF);
      next_cyc();
      take_action_ocimem_a = 1'b0;
      at_neg();
      check("ldaddr_no_busy", 32'(jtag_busy), 32'd0);
      check("ldaddr_no_rden", 32'(ram_rden), 32'd0);
      check("ldaddr_no_wren", 32'(ram_wren), 32'd0);
      next_cyc();
      take_action_ocimem_b = 1'b1;
      jdo = jdo_b(32'h0BADF00D);
      next_cyc();
      jdo = jdo_b(32'h0C0FFEE0);
      at_neg();
      check("wrap_wren", 32'(ram_wren), 32'd1);
      check("wrap_addr_ff", 32'(ram_addr), 32'hFF);
      check("wrap_data_ff", ram_wrdata, 32'h0BADF00D);
      next_cyc();
      take_action_ocimem_b = 1'b0;
      at_neg();
      check("wrap_addr_00", 32'(ram_addr), 32'h00);
      check("wrap_data_00", ram_wrdata, 32'h0C0FFEE0);
      next_cyc();
      at_neg();
      check("wrap_idle", 32'(jtag_busy), 32'd0);
      check("wrap_mem_ff", mem[255], 32'h0BADF00D);

      // Reset in the middle of an Avalon read.
      next_cyc();
      av_read = 1'b1;
      av_address = 8'h10;
      at_neg();
      check("midrst_rden", 32'(ram_rden), 32'd1);
      next_cyc();
      reset_n = 1'b0;
      at_neg();
      check("midrst_waitreq", 32'(av_waitrequest), 32'd1);
      check("midrst_readdata", av_readdata, 32'h0);
      check("midrst_ovr_clr", 32'(jtag_overrun), 32'd0);
      next_cyc();
      reset_n = 1'b1;
      av_read = 1'b0;
      at_neg();
      check("postrst_waitreq", 32'(av_waitrequest), 32'd1);
      check("postrst_readdata", av_readdata, 32'h0);
      next_cyc();
      av_read = 1'b1;
      av_address = 8'h05;
      at_neg();
      check("postrst_idle_grant", 32'(ram_rden), 32'd1);
      check("postrst_addr", 32'(ram_addr), 32'h05);
      next_cyc();
      at_neg();
      check("postrst_data", av_readdata, 32'hAAAA5678);
      next_cyc();
      av_read = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
